// File: rtl/video_out_gen_if.sv
// ---------------------------------------------------------------------------
// video_out_gen_if
// FIFO read-side handshake between the output FIFO (first-word-fall-through)
// and the video output generator.
//
// Signals:
//   fifo_empty : FIFO has no word; data_in is invalid while high
//   data_in    : FWFT head word, [31:24] is the first pixel on screen
//   r_e        : pop strobe, one clk pulse per consumed word
//
// Modports:
//   master : the consumer (video_out_gen) - drives r_e
//   slave  : the FIFO - drives fifo_empty and data_in
// ---------------------------------------------------------------------------
interface video_out_gen_if;
    logic        fifo_empty;
    logic [31:0] data_in;
    logic        r_e;

    modport master (
        input  fifo_empty,
        input  data_in,
        output r_e
    );

    modport slave (
        output fifo_empty,
        output data_in,
        input  r_e
    );
endinterface

// File: rtl/video_out_gen.sv
// ---------------------------------------------------------------------------
// video_out_gen
// Transmit-side video timing generator. Pops 32-bit packed pixel words from
// a FWFT FIFO, unpacks each into four 8-bit pixels (MSB byte first) and
// drives pixel_out with line_valid/frame_valid framing, one pixel per clk,
// followed by horizontal and vertical blanking.
//
// Ports:
//   clk         : pixel clock, all logic on posedge
//   RST         : asynchronous active-high reset
//   enable      : start/continue frame generation, sampled at frame boundaries
//   fifo        : FIFO read handshake (fifo_empty, data_in, r_e)
//   line_valid  : high during the active pixels of an active line
//   frame_valid : high for the whole period of every active line
//   pixel_out   : current pixel, 0x00 whenever line_valid is low
//   underrun    : sticky flag, set when a word is needed and the FIFO is empty
// ---------------------------------------------------------------------------
module video_out_gen #(
    parameter int unsigned p_WIDTH  = 640,
    parameter int unsigned p_HEIGHT = 480,
    parameter int unsigned p_LSYNC  = 160,
    parameter int unsigned p_FSYNC  = 40
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            enable,
    video_out_gen_if.master fifo,
    output logic            line_valid,
    output logic            frame_valid,
    output logic [7:0]      pixel_out,
    output logic            underrun
);

    // Last counter values of a line / frame and the active-region limits.
    localparam logic [9:0] H_LAST = 10'(p_WIDTH + p_LSYNC - 1);
    localparam logic [9:0] V_LAST = 10'(p_HEIGHT + p_FSYNC - 1);
    localparam logic [9:0] H_ACT  = 10'(p_WIDTH);
    localparam logic [9:0] V_ACT  = 10'(p_HEIGHT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [23:0] shift_q;

    logic        running;
    logic        active;
    logic        grp_start;
    logic        frame_end;
    logic        pop;

    assign running   = (state == RUN);
    assign active    = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign grp_start = (h_cnt[1:0] == 2'b00);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and pop strobe. enable is only looked at while idle or
    // on the very last clk of a frame, so a frame always runs to completion.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && !fifo.fifo_empty) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (frame_end && !enable) begin
                    state_nxt = IDLE;
                end
                pop = active && grp_start && !fifo.fifo_empty;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fifo.r_e = pop;

    // -----------------------------------------------------------------------
    // Raster counters: held at zero while idle, so the first RUN clk is
    // position (0,0).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (running) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end else begin
            h_cnt <= '0;
            v_cnt <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs and unpacking. A missing word at a group start
    // clears the shift register, so the remaining three pixels of that group
    // come out as 0x00 without a separate "group failed" flag.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            pixel_out   <= '0;
            shift_q     <= '0;
            underrun    <= 1'b0;
        end else begin
            line_valid  <= active;
            frame_valid <= running && (v_cnt < V_ACT);
            if (active) begin
                unique case (h_cnt[1:0])
                    2'd0: begin
                        if (pop) begin
                            pixel_out <= fifo.data_in[31:24];
                            shift_q   <= fifo.data_in[23:0];
                        end else begin
                            pixel_out <= '0;
                            shift_q   <= '0;
                            underrun  <= 1'b1;
                        end
                    end
                    2'd1:    pixel_out <= shift_q[23:16];
                    2'd2:    pixel_out <= shift_q[15:8];
                    default: pixel_out <= shift_q[7:0];
                endcase
            end else begin
                pixel_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_video_out_gen.sv
// ---------------------------------------------------------------------------
// tb_video_out_gen
// Self-checking bench for video_out_gen on a reduced raster. A reference
// model tracks the frame as a linear position (h = pos % line, v = pos / line)
// and the pixel of each group as a byte of the word fetched at its start.
// ---------------------------------------------------------------------------
module tb_video_out_gen;

    localparam int W     = 16;
    localparam int H     = 6;
    localparam int LS    = 5;
    localparam int FS    = 3;
    localparam int LINE  = W + LS;
    localparam int FRAME = LINE * (H + FS);

    logic       clk = 1'b0;
    logic       RST;
    logic       enable;
    logic       line_valid;
    logic       frame_valid;
    logic [7:0] pixel_out;
    logic       underrun;

    video_out_gen_if fif();

    video_out_gen #(
        .p_WIDTH (W),
        .p_HEIGHT(H),
        .p_LSYNC (LS),
        .p_FSYNC (FS)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .enable     (enable),
        .fifo       (fif),
        .line_valid (line_valid),
        .frame_valid(frame_valid),
        .pixel_out  (pixel_out),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // bench FIFO
    logic [31:0] q[$];
    bit          force_empty;
    bit          pop_armed;

    // reference model
    bit          m_run;
    int          m_pos;
    logic [31:0] m_grp;
    bit          m_ur;
    bit          exp_lv;
    bit          exp_fv;
    logic [7:0]  exp_px;

    // observation counters
    int          checks;
    int          errors;
    int          cnt_lv;
    int          cnt_fv;
    int          cnt_pop;
    logic [7:0]  px_seen[$];
    int          cyc;
    int          last_rise;
    int          period_seen;
    bit          prev_fv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh_fifo();
        fif.fifo_empty = force_empty || (q.size() == 0);
        if (fif.fifo_empty) fif.data_in = '0;
        else                fif.data_in = q[0];
    endtask

    task automatic refill(input int pct);
        if (q.size() < 8 && $urandom_range(99) < pct) q.push_back($urandom);
    endtask

    // Compare DUT against the model at the falling edge, then advance the
    // model by one clk using the inputs the DUT will see at the next edge.
    task automatic monitor();
        int h;
        int v;
        bit act;
        cyc++;
        if (RST) begin
            m_run = 0; m_pos = 0; m_grp = '0; m_ur = 0;
            exp_lv = 0; exp_fv = 0; exp_px = '0; prev_fv = 0;
            check("rst_line_valid", line_valid, 0);
            check("rst_frame_valid", frame_valid, 0);
            check("rst_pixel_out", pixel_out, 0);
            check("rst_underrun", underrun, 0);
            check("rst_r_e", fif.r_e, 0);
            return;
        end
        check("line_valid", line_valid, exp_lv);
        check("frame_valid", frame_valid, exp_fv);
        check("pixel_out", pixel_out, exp_px);
        check("underrun", underrun, m_ur);

        h   = m_pos % LINE;
        v   = m_pos / LINE;
        act = m_run && (h < W) && (v < H);
        check("r_e", fif.r_e, act && (h % 4 == 0) && !fif.fifo_empty);

        if (fif.r_e === 1'b1) cnt_pop++;
        if (line_valid) begin
            cnt_lv++;
            px_seen.push_back(pixel_out);
        end
        if (frame_valid) cnt_fv++;
        if (frame_valid && !prev_fv) begin
            if (last_rise >= 0) period_seen = cyc - last_rise;
            last_rise = cyc;
        end
        prev_fv = frame_valid;

        exp_lv = act;
        exp_fv = m_run && (v < H);
        if (act && (h % 4 == 0)) begin
            if (fif.fifo_empty) begin
                m_grp = '0;
                m_ur  = 1;
            end else begin
                m_grp = fif.data_in;
            end
        end
        exp_px = act ? 8'(m_grp >> (8 * (3 - (h % 4)))) : 8'h00;

        if (m_run) begin
            if (m_pos == FRAME - 1) begin
                m_pos = 0;
                m_run = enable;
            end else begin
                m_pos++;
            end
        end else if (enable && !fif.fifo_empty) begin
            m_run = 1;
            m_pos = 0;
        end
    endtask

    // One clk: returns at posedge+1 so the caller can change stimulus.
    task automatic step();
        refresh_fifo();
        @(negedge clk);
        monitor();
        pop_armed = (fif.r_e === 1'b1) && !RST;
        @(posedge clk);
        #1;
        if (pop_armed && q.size() > 0) void'(q.pop_front());
        pop_armed = 0;
        refresh_fifo();
    endtask

    task automatic run_to_idle();
        for (int i = 0; i < 3 * FRAME && m_run; i++) begin
            refill(100);
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        last_rise = -1; period_seen = 0;
        RST = 1'b1; enable = 1'b0; force_empty = 0; pop_armed = 0;
        refresh_fifo();
        repeat (3) step();
        RST = 1'b0;
        repeat (4) step();

        // enable with an empty FIFO must not start
        enable = 1'b1;
        repeat (6) step();
        check("idle_empty_fv", frame_valid, 0);

        // single frame with sequential bytes, enable pulsed
        cnt_lv = 0; cnt_fv = 0; cnt_pop = 0; px_seen.delete();
        for (int k = 0; k < W * H / 4; k++)
            q.push_back({8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
        step();
        enable = 1'b0;
        for (int i = 0; i < 2 * FRAME && m_run; i++) step();
        repeat (3) step();
        check("frame1_lv_clks", cnt_lv, W * H);
        check("frame1_fv_clks", cnt_fv, H * LINE);
        check("frame1_pops", cnt_pop, W * H / 4);
        check("frame1_fifo_drained", q.size(), 0);
        check("frame1_idle_fv", frame_valid, 0);
        check("frame1_no_underrun", underrun, 0);
        for (int i = 0; i < W * H && i < px_seen.size(); i++)
            check($sformatf("frame1_px%0d", i), px_seen[i], i);

        // continuous enable, forced empty at h=8,v=3, then stop at v=2
        last_rise = -1; period_seen = 0;
        enable = 1'b1;
        for (int i = 0; i < 3 * FRAME && !(m_run && m_pos == 3 * LINE + 8); i++) begin
            refill(100);
            step();
        end
        force_empty = 1;
        repeat (4) begin
            refill(100);
            step();
        end
        force_empty = 0;
        check("underrun_set", underrun, 1);
        for (int i = 0; i < 3 * FRAME && !(m_run && m_pos == 2 * LINE); i++) begin
            refill(100);
            step();
        end
        enable = 1'b0;
        run_to_idle();
        repeat (4) step();
        check("frame_period", period_seen, FRAME);
        check("stop_idle_fv", frame_valid, 0);
        check("underrun_sticky", underrun, 1);

        // random FIFO availability and enable toggling
        for (int i = 0; i < 5 * FRAME; i++) begin
            if ($urandom_range(63) == 0) enable = ~enable;
            force_empty = ($urandom_range(15) == 0);
            refill(60);
            step();
        end
        force_empty = 0;
        enable = 1'b0;
        run_to_idle();

        // reset in the middle of an active line
        enable = 1'b1;
        for (int i = 0; i < 3 * FRAME && !(m_run && m_pos == LINE + 5); i++) begin
            refill(100);
            step();
        end
        check("pre_rst_lv", line_valid, 1);
        RST = 1'b1;
        #1;
        check("async_rst_lv", line_valid, 0);
        check("async_rst_fv", frame_valid, 0);
        check("async_rst_px", pixel_out, 0);
        check("async_rst_ur", underrun, 0);
        repeat (3) step();
        RST = 1'b0;
        enable = 1'b0;
        repeat (5) step();
        check("post_rst_idle_fv", frame_valid, 0);
        enable = 1'b1;
        repeat (3) step();
        check("restart_fv", frame_valid, 1);
        enable = 1'b0;
        run_to_idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
